pipe_stage_chain: RTL

//  Parametrised chain of DEPTH pipeline registers, WIDTH bits each, with valid/ready handshake,
//  per-stage flush and global stall. Used between IF/ID/EX/MEM/WB to pipeline the datapath.

---
 rtl/pipe_stage_chain.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//   A chain of DEPTH pipeline registers, WIDTH bits each, with a valid/ready
//   handshake at both ends, a per-stage flush and a global stall. Hazard logic
//   drives flush/stall. With COLLAPSE=1 each stage has its own ready, so bubbles
//   are squeezed out while the downstream end is blocked. With COLLAPSE=0 the
//   whole chain moves on one shared enable.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   in_valid   upstream offers in_data
//   in_ready   chain accepts in_data at this edge
//   in_data    payload into stage 0
//   out_valid  last stage holds a live item
//   out_ready  downstream takes out_data at this edge
//   out_data   payload of the last stage
//   flush      bit i kills the item in stage i at this edge
//   stall      freeze: no stage moves, no handshake
//   count      number of live stages (registered)
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter bit COLLAPSE = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic [DEPTH-1:0]           flush,
    input  logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    logic [DEPTH-1:0] ev;       // valid after this edge's flush
    logic [DEPTH:0]   rdy;      // rdy[i]: stage i may load this edge
    logic [DEPTH-1:0] inc_v;    // valid of the item offered to stage i
    logic [WIDTH-1:0] inc_d [DEPTH];
    logic             in_xfer;

    assign ev        = v_q & ~flush;
    assign out_valid = ev[DEPTH-1] & ~stall & reset;
    assign out_data  = d_q[DEPTH-1];
    assign in_ready  = rdy[0] & ~stall & reset;
    assign in_xfer   = in_valid & in_ready;
    assign count     = count_q;

    // Readiness ripples from the output end back towards stage 0.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (COLLAPSE)
                rdy[i] = ~ev[i] | rdy[i+1];
            else
                rdy[i] = ~ev[DEPTH-1] | out_ready;
        end
    end

    // What each stage would receive if it loads: the input port for stage 0,
    // the flushed view of the previous stage otherwise (flushed items become
    // bubbles and never advance).
    always_comb begin
        inc_v    = '0;
        inc_v[0] = in_xfer;
        inc_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            inc_v[i] = ev[i-1];
            inc_d[i] = d_q[i-1];
        end
    end

    always_comb begin
        v_d     = ev;
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            d_d[i] = d_q[i];
            if (!stall && rdy[i]) begin
                v_d[i] = inc_v[i];
                // Payload only moves with a live item; a bubble leaves the
                // stale payload in place.
                if (inc_v[i])
                    d_d[i] = inc_d[i];
            end
        end
        for (int i = 0; i < DEPTH; i++)
            count_d = count_d + CW'(v_d[i]);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            v_q     <= '0;
            count_q <= '0;
            // NOTE: the payload array is cleared on reset as well, so out_data
            // is defined (zero) straight after reset rather than left unknown.
            for (int i = 0; i < DEPTH; i++)
                d_q[i] <= '0;
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++)
                d_q[i] <= d_d[i];
        end
    end

endmodule
